// File: rtl/ternary_to_binary_converter.sv
// Serial ternary-to-binary converter (Horner, MSD first, one digit per clock).
// Optional invalid-digit check enabled by defining TERNARY_CONV_CHECK_EN.
module ternary_to_binary_converter #(
    parameter int unsigned N  = 1,
    parameter int unsigned BW = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2*N-1:0]  sum,
    input  logic            cOut,
    output logic            busy,
    output logic            done,
    output logic [BW-1:0]   value,
    output logic            err
);

    localparam int unsigned SW = 2 * N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   sr;
    logic [CW-1:0]   cnt;
    logic [1:0]      digit;
    logic [1:0]      digit_val;
    logic [BW-1:0]   acc_next;

    // Horner step: value*3 + current MSD, wrapping modulo 2^BW
    always_comb begin
        digit     = sr[SW-1 -: 2];
        digit_val = digit;
`ifdef TERNARY_CONV_CHECK_EN
        if (digit == 2'b11) begin
            digit_val = 2'b00;
        end
`endif
        acc_next = BW'({value, 1'b0}) + value + BW'(digit_val);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            value <= '0;
            sr    <= '0;
            cnt   <= '0;
`ifdef TERNARY_CONV_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sr    <= sum;
                        value <= BW'(cOut);
                        cnt   <= CW'(N - 1);
                        busy  <= 1'b1;
                        state <= CONV;
`ifdef TERNARY_CONV_CHECK_EN
                        err   <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    value <= acc_next;
                    sr    <= sr << 2;
`ifdef TERNARY_CONV_CHECK_EN
                    if (digit == 2'b11) begin
                        err <= 1'b1;
                    end
`endif
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef TERNARY_CONV_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_to_binary_converter.sv
// Self-checking bench: directed and random conversions on N=2/BW=5 and N=1/BW=3 instances.
module tb_ternary_to_binary_converter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       start_a = 1'b0;
    logic [3:0] sum_a = '0;
    logic       cout_a = 1'b0;
    logic       busy_a, done_a, err_a;
    logic [4:0] value_a;

    logic       start_b = 1'b0;
    logic [1:0] sum_b = '0;
    logic       cout_b = 1'b0;
    logic       busy_b, done_b, err_b;
    logic [2:0] value_b;

    int tests = 0;
    int fails = 0;

    ternary_to_binary_converter #(.N(2), .BW(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .sum(sum_a), .cOut(cout_a),
        .busy(busy_a), .done(done_a), .value(value_a), .err(err_a)
    );

    ternary_to_binary_converter #(.N(1), .BW(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .sum(sum_b), .cOut(cout_b),
        .busy(busy_b), .done(done_b), .value(value_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: cOut*3^2 + d1*3 + d0, modulo 2^5; invalid digit handling depends on build
    function automatic int ref_val(input logic [3:0] s, input logic c);
        int v = int'(c) * 9;
        for (int k = 0; k < 2; k++) begin
            int d = int'(s[2*k +: 2]);
`ifdef TERNARY_CONV_CHECK_EN
            if (d == 3) d = 0;
`endif
            v += d * ((k == 0) ? 1 : 3);
        end
        return v % 32;
    endfunction

    function automatic int ref_err(input logic [3:0] s);
`ifdef TERNARY_CONV_CHECK_EN
        return (s[3:2] == 2'b11 || s[1:0] == 2'b11) ? 1 : 0;
`else
        return (s == 4'hF && s != 4'hF) ? 1 : 0;
`endif
    endfunction

    // One full conversion on the N=2 instance with inputs scrambled after acceptance
    task automatic conv_a(input string tag, input logic [3:0] s, input logic c);
        start_a = 1'b1; sum_a = s; cout_a = c;
        tick();
        start_a = 1'b0; sum_a = 4'($urandom); cout_a = 1'($urandom);
        chk({tag, "_busy_e0"}, int'(busy_a), 1);
        chk({tag, "_done_e0"}, int'(done_a), 0);
        tick();
        chk({tag, "_busy_e1"}, int'(busy_a), 1);
        tick();
        chk({tag, "_busy_e2"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 1);
        chk({tag, "_value"}, int'(value_a), ref_val(s, c));
        chk({tag, "_err"}, int'(err_a), ref_err(s));
        tick();
        chk({tag, "_done_drop"}, int'(done_a), 0);
        chk({tag, "_value_hold"}, int'(value_a), ref_val(s, c));
    endtask

    initial begin
        logic [3:0] s_acc;
        logic       c_acc;

        #3;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_value", int'(value_a), 0);
        chk("rst_err", int'(err_a), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Directed conversions
        conv_a("d21_c1", 4'b1001, 1'b1);
        chk("d21_c1_abs", int'(value_a), 16);
        conv_a("zero", 4'b0000, 1'b0);
        chk("zero_abs", int'(value_a), 0);
        conv_a("max", 4'b1010, 1'b1);
        chk("max_abs", int'(value_a), 17);

        // Invalid MSD: err visible right after E1
        start_a = 1'b1; sum_a = 4'b1101; cout_a = 1'b0;
        tick();
        start_a = 1'b0;
        tick();
`ifdef TERNARY_CONV_CHECK_EN
        chk("inv_err_e1", int'(err_a), 1);
`else
        chk("inv_err_e1", int'(err_a), 0);
`endif
        tick();
        chk("inv_done", int'(done_a), 1);
`ifdef TERNARY_CONV_CHECK_EN
        chk("inv_value", int'(value_a), 1);
`else
        chk("inv_value", int'(value_a), 10);
`endif
        tick();
        conv_a("clear_err", 4'b0001, 1'b0);

        // Start held high: accepts only on done cycles, one result every 3 cycles
        s_acc = 4'($urandom_range(0, 15)); c_acc = 1'($urandom);
        start_a = 1'b1; sum_a = s_acc; cout_a = c_acc;
        tick();
        for (int r = 0; r < 5; r++) begin
            sum_a = 4'($urandom); cout_a = 1'($urandom);
            tick();
            chk("b2b_busy_e1", int'(busy_a), 1);
            chk("b2b_nodone_e1", int'(done_a), 0);
            sum_a = 4'($urandom); cout_a = 1'($urandom);
            tick();
            chk("b2b_done", int'(done_a), 1);
            chk("b2b_value", int'(value_a), ref_val(s_acc, c_acc));
            s_acc = 4'($urandom_range(0, 15)); c_acc = 1'($urandom);
            sum_a = s_acc; cout_a = c_acc;
            tick();
            chk("b2b_accept_busy", int'(busy_a), 1);
            chk("b2b_accept_nodone", int'(done_a), 0);
        end
        start_a = 1'b0;
        tick(); tick(); tick();

        // Asynchronous reset after E1
        start_a = 1'b1; sum_a = 4'b1010; cout_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_done", int'(done_a), 0);
        chk("arst_value", int'(value_a), 0);
        chk("arst_err", int'(err_a), 0);
        tick(); tick();
        chk("arst_hold_done", int'(done_a), 0);
        reset_n = 1'b1;
        tick();
        conv_a("post_rst", 4'b0110, 1'b0);

        // Random conversions
        for (int i = 0; i < 20; i++) begin
            conv_a("rand", 4'($urandom_range(0, 15)), 1'($urandom));
        end

        // N=1 instance: every legal (cOut, digit)
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 3; d++) begin
                start_b = 1'b1; sum_b = 2'(d); cout_b = 1'(c);
                tick();
                start_b = 1'b0; sum_b = 2'($urandom);
                chk("n1_busy", int'(busy_b), 1);
                chk("n1_nodone", int'(done_b), 0);
                tick();
                chk("n1_done", int'(done_b), 1);
                chk("n1_value", int'(value_b), 3 * c + d);
                chk("n1_err", int'(err_b), 0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
